counter_move_scheduler: RTL



---
 rtl/counter_move_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/counter_move_scheduler.sv
// -----------------------------------------------------------------------------
// counter_move_scheduler
//
// Arbitrated move controller for a WIDTH-bit up/down ring counter. Two
// requesters each submit a target position. One request is accepted at a time,
// round-robin between the two. The shortest direction around the ring is
// chosen, and the block issues paced single-step commands until the tracked
// position reaches the target. A one-cycle done pulse then goes to the owner.
//
// Parameters
//   WIDTH     position width; the ring has 2**WIDTH positions
//   HOLD      idle cycles between consecutive steps (1..255)
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   req[1:0]  per-requester request level, held until the matching gnt bit
//   tgt0      target of requester 0, stable while req[0]=1
//   tgt1      target of requester 1, stable while req[1]=1
//   gnt[1:0]  one-hot acceptance pulse (first cycle after acceptance)
//   done[1:0] one-hot completion pulse to the owning requester
//   busy      high whenever the controller is not idle
//   cnt_step  one-cycle advance command to the counter
//   cnt_dir   0 = up (+1), 1 = down (-1); qualified by cnt_step
//   pos       tracked counter position
// -----------------------------------------------------------------------------
module counter_move_scheduler #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             cnt_step,
  output logic             cnt_dir,
  output logic [WIDTH-1:0] pos
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Half the ring: a distance of exactly this much is a tie and goes up.
  localparam logic [WIDTH-1:0] HALF      = WIDTH'(1 << (WIDTH - 1));
  // WAIT is left when the counter reaches zero, so HOLD-1 gives HOLD cycles.
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q;
  logic [WIDTH-1:0] tgt_q;
  logic             id_q;
  logic             dir_q;
  logic             last_q;      // requester accepted most recently
  logic             first_q;     // first cycle after an acceptance
  logic [7:0]       hold_q;

  logic             win_id;
  logic [WIDTH-1:0] win_tgt;
  logic [WIDTH-1:0] win_diff;
  logic             win_dir;
  logic [WIDTH-1:0] pos_step;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    // On a contest the requester not served last wins; otherwise the only
    // active requester wins.
    win_id   = (req == 2'b11) ? ~last_q : req[1];
    win_tgt  = win_id ? tgt1 : tgt0;
    // Modular distance going up; beyond half the ring, going down is shorter.
    win_diff = win_tgt - pos_q;
    win_dir  = (win_diff > HALF);
    // Natural WIDTH-bit wrap gives the ring behaviour (max+1=0, 0-1=max).
    pos_step = dir_q ? (pos_q - WIDTH'(1)) : (pos_q + WIDTH'(1));

    state_d = state_q;
    unique case (state_q)
      IDLE: if (|req)            state_d = (win_tgt == pos_q) ? DONE : MOVE;
      MOVE:                      state_d = (pos_step == tgt_q) ? DONE : WAIT;
      WAIT: if (hold_q == 8'd0)  state_d = MOVE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it takes effect only on a clock edge and
    // covers every register, so a mid-move reset never leaves a partial step.
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      tgt_q   <= '0;
      id_q    <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == IDLE) && (|req);
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            tgt_q  <= win_tgt;
            id_q   <= win_id;
            dir_q  <= win_dir;
            last_q <= win_id;
          end
        end
        MOVE: begin
          pos_q  <= pos_step;
          hold_q <= HOLD_LOAD;
        end
        WAIT: begin
          if (hold_q != 8'd0) hold_q <= hold_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  assign busy     = (state_q != IDLE);
  assign cnt_step = (state_q == MOVE);
  assign cnt_dir  = dir_q;
  assign pos      = pos_q;
  assign gnt      = first_q ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign done     = (state_q == DONE) ? (id_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
